activity_4_serial_adder: RTL and testbench

//   Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in,

---
 rtl/activity_4_serial_adder.sv | 128 ++++++++++++
 tb/tb_activity_4_serial_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/activity_4_serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in DIGIT bits per clock
// through a DIGIT-bit ripple chain and a registered carry, with a start/done handshake.
module activity_4_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("activity_4_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   chain;
    logic             last;

    always_comb begin : digit_adder
        chain    = '0;
        dsum     = '0;
        chain[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]      = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
        end
    end

    assign last = (cnt_q == CW'(N - 1));

    always_comb begin : next_state
        // NOTE: every next-state signal gets a hold default first, so no path through
        // the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Result digits enter at the MSB end, so after N steps digit 0 sits at bit 0.
                acc_d   = (WIDTH'(dsum) << (WIDTH - DIGIT)) | (acc_q >> DIGIT);
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = chain[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = acc_d;
                    cout_d  = chain[DIGIT];
                    ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_activity_4_serial_adder.sv
// Bench for activity_4_serial_adder: three configurations (8/1, 4/2, 8/4) checked
// through per-instance scoreboards popped on each done pulse.
module tb_activity_4_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8, DIGIT=1
    logic       s8_start, s8_cin, s8_cout, s8_ovf, s8_busy, s8_done;
    logic [7:0] s8_a, s8_b, s8_sum;
    // WIDTH=4, DIGIT=2
    logic       s4_start, s4_cin, s4_cout, s4_ovf, s4_busy, s4_done;
    logic [3:0] s4_a, s4_b, s4_sum;
    // WIDTH=8, DIGIT=4
    logic       s84_start, s84_cin, s84_cout, s84_ovf, s84_busy, s84_done;
    logic [7:0] s84_a, s84_b, s84_sum;

    activity_4_serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin),
        .sum(s8_sum), .cout(s8_cout), .overflow(s8_ovf), .busy(s8_busy), .done(s8_done));
    activity_4_serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
        .sum(s4_sum), .cout(s4_cout), .overflow(s4_ovf), .busy(s4_busy), .done(s4_done));
    activity_4_serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(s84_start), .a(s84_a), .b(s84_b), .cin(s84_cin),
        .sum(s84_sum), .cout(s84_cout), .overflow(s84_ovf), .busy(s84_busy), .done(s84_done));

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         k;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    exp_t q8[$], q4[$], q84[$];
    exp_t e8, e4, e84;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer add, overflow from operand/result sign bits.
    function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
        logic [8:0] full;
        logic [7:0] s;
        logic [7:0] mask;
        logic       co, ov;
        full = {1'b0, a} + {1'b0, b} + {8'b0, c};
        mask = 8'((1 << w) - 1);
        s    = full[7:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    function automatic int qsize(input int which);
        case (which)
            8:       return q8.size();
            4:       return q4.size();
            default: return q84.size();
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && s8_done) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL u8_unexpected_done: done=1 with no add pending (cycle %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                check("u8_sum", s8_sum, e8.sum);
                check("u8_cout", s8_cout, e8.cout);
                check("u8_ovf", s8_ovf, e8.ovf);
                check("u8_latency", cyc - e8.k, 8);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s4_done) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL u4_unexpected_done: done=1 with no add pending (cycle %0d)", cyc);
            end else begin
                e4 = q4.pop_front();
                check("u4_sum", s4_sum, e4.sum);
                check("u4_cout", s4_cout, e4.cout);
                check("u4_ovf", s4_ovf, e4.ovf);
                check("u4_latency", cyc - e4.k, 2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s84_done) begin
            if (q84.size() == 0) begin
                total++; bad++;
                $display("FAIL u84_unexpected_done: done=1 with no add pending (cycle %0d)", cyc);
            end else begin
                e84 = q84.pop_front();
                check("u84_sum", s84_sum, e84.sum);
                check("u84_cout", s84_cout, e84.cout);
                check("u84_ovf", s84_ovf, e84.ovf);
                check("u84_latency", cyc - e84.k, 2);
            end
        end
    end

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec, input logic eo);
        s8_a = a; s8_b = b; s8_cin = c; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        q8.push_back('{sum: es, cout: ec, ovf: eo, k: cyc});
    endtask

    task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [9:0] r;
        r = model(4, {4'b0, a}, {4'b0, b}, c);
        s4_a = a; s4_b = b; s4_cin = c; s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        q4.push_back('{sum: r[7:0], cout: r[8], ovf: r[9], k: cyc});
    endtask

    task automatic wait_empty(input int which);
        int n = 0;
        while (qsize(which) != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("q%0d_drained", which), qsize(which), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] oa[9], ob[9];
        logic       oc[9];
        logic [9:0] r;
        logic [8:0] xv;

        vecs[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[1] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[2] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'h3C, b: 8'h45, cin: 1'b1, sum: 8'h82, cout: 1'b0, ovf: 1'b1};
        vecs[6] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 8'h7F, b: 8'h7F, cin: 1'b1, sum: 8'hFF, cout: 1'b0, ovf: 1'b1};

        s8_start = 0;  s8_a = 0;  s8_b = 0;  s8_cin = 0;
        s4_start = 0;  s4_a = 0;  s4_b = 0;  s4_cin = 0;
        s84_start = 0; s84_a = 0; s84_b = 0; s84_cin = 0;

        // Reset state
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_sum", s8_sum, 0);
        check("rst_cout", s8_cout, 0);
        check("rst_ovf", s8_ovf, 0);
        check("rst_busy", s8_busy, 0);
        check("rst_done", s8_done, 0);
        check("rst_u4_busy", s4_busy, 0);
        check("rst_u84_done", s84_done, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors on the bit-serial instance
        for (int i = 0; i < 8; i++) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            check("u8_busy_in_run", s8_busy, 1);
            wait_empty(8);
        end

        // Result holds through the next RUN until that add completes
        start8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        check("u8_hold_sum_run1", s8_sum, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("u8_hold_sum_run4", s8_sum, 8'hFF);
        check("u8_hold_ovf_run4", s8_ovf, 1);
        wait_empty(8);

        // start during RUN cycle 3 is ignored; exactly one done follows
        start8(8'hC8, 8'hA0, 1'b0, 8'h68, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        s8_a = 8'hFF; s8_b = 8'hFF; s8_cin = 1'b1; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        wait_empty(8);
        repeat (12) @(posedge clk);
        #1;

        // Reset at RUN cycle 4 aborts the add
        start8(8'h55, 8'h22, 1'b1, 8'h78, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_sum", s8_sum, 0);
        check("midrst_cout", s8_cout, 0);
        check("midrst_ovf", s8_ovf, 0);
        check("midrst_busy", s8_busy, 0);
        check("midrst_done", s8_done, 0);
        q8.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        start8(8'h55, 8'h22, 1'b1, 8'h78, 1'b0, 1'b0);
        wait_empty(8);

        // Exhaustive WIDTH=4, DIGIT=2
        for (int x = 0; x < 512; x++) begin
            xv = x[8:0];
            start4(xv[7:4], xv[3:0], xv[8]);
            wait_empty(4);
        end

        // Back-to-back with start held high on WIDTH=8, DIGIT=4
        for (int i = 0; i < 9; i++) begin
            oa[i] = 8'($urandom);
            ob[i] = 8'($urandom);
            oc[i] = 1'($urandom);
        end
        s84_a = oa[0]; s84_b = ob[0]; s84_cin = oc[0]; s84_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            r = model(8, oa[i], ob[i], oc[i]);
            q84.push_back('{sum: r[7:0], cout: r[8], ovf: r[9], k: cyc});
            s84_a = oa[i+1]; s84_b = ob[i+1]; s84_cin = oc[i+1];
            repeat (2) @(posedge clk);
            #1;
            if (i == 7) s84_start = 1'b0;
        end
        wait_empty(84);
        repeat (6) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
